// File: rtl/pwm_cfg_pkg.sv
// Shared op codes, response status codes and sequencer states for the pwm
// configuration controller.
package pwm_cfg_pkg;

  typedef enum logic [1:0] {
    OP_CONFIG   = 2'd0,
    OP_ENABLE   = 2'd1,
    OP_DISABLE  = 2'd2,
    OP_READBACK = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_MISMATCH  = 2'd1,
    ST_BAD_CH    = 2'd2,
    ST_BAD_PARAM = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_VERIFY = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  localparam int DEF_NUM_CH         = 4;
  localparam int DEF_WAVE_LEN_WIDTH = 11;

  // Channel index width; a single-bit index is kept even for degenerate sizes.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_cfg_sequencer_readback_mux.sv
// Combinational channel select of the packed pwm readback buses; an index
// outside the bank reads as all zeros.
module pwm_readback_mux
  import pwm_cfg_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int WAVE_LEN_WIDTH = DEF_WAVE_LEN_WIDTH,
  localparam int CH_W          = ch_width(NUM_CH),
  localparam int W             = WAVE_LEN_WIDTH
) (
  input  logic [CH_W-1:0]     ch,
  input  logic [NUM_CH*W-1:0] wave_length_bus,
  input  logic [NUM_CH*W-1:0] pulse_width_bus,
  input  logic [NUM_CH-1:0]   active_high_bus,
  output logic [W-1:0]        wave_length,
  output logic [W-1:0]        pulse_width,
  output logic                active_high
);

  always_comb begin
    wave_length = '0;
    pulse_width = '0;
    active_high = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CH_W'(i)) begin
        wave_length = wave_length_bus[i*W +: W];
        pulse_width = pulse_width_bus[i*W +: W];
        active_high = active_high_bus[i];
      end
    end
  end

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Command-driven configuration sequencer for a bank of pwm channels: drives the
// shared parameter bus, per-channel update strobes and enables, one response per command.
module pwm_cfg_sequencer
  import pwm_cfg_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int WAVE_LEN_WIDTH = DEF_WAVE_LEN_WIDTH,
  localparam int CH_W          = ch_width(NUM_CH),
  localparam int W             = WAVE_LEN_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [CH_W-1:0]     cmd_ch,
  input  logic [W-1:0]        cmd_wave_length,
  input  logic [W-1:0]        cmd_pulse_width,
  input  logic                cmd_active_high,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_status,
  output logic [W-1:0]        rsp_wave_length,
  output logic [W-1:0]        rsp_pulse_width,
  output logic                rsp_active_high,
  output logic [NUM_CH-1:0]   pwm_update,
  output logic [W-1:0]        pwm_wave_length,
  output logic [W-1:0]        pwm_pulse_width,
  output logic                pwm_active_high,
  output logic [NUM_CH-1:0]   pwm_enable,
  input  logic [NUM_CH*W-1:0] ch_wave_length_in,
  input  logic [NUM_CH*W-1:0] ch_pulse_width_in,
  input  logic [NUM_CH-1:0]   ch_active_high_in
);

  state_e            state;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   sel_ch;
  logic [W-1:0]      rb_wave_length;
  logic [W-1:0]      rb_pulse_width;
  logic              rb_active_high;
  logic              bad_ch;
  logic              bad_param;
  logic              is_config;
  logic              rb_match;
  logic [NUM_CH-1:0] cmd_mask;
  logic [NUM_CH-1:0] ch_q_mask;

  assign cmd_ready = (state == S_IDLE) && !reset;

  // In IDLE the readback follows the incoming command so ENABLE/DISABLE/READBACK
  // can capture it at the accept edge; later it follows the latched channel.
  assign sel_ch = (state == S_IDLE) ? cmd_ch : ch_q;

  assign bad_ch    = {1'b0, cmd_ch} >= (CH_W + 1)'(NUM_CH);
  assign bad_param = (cmd_wave_length == '0) || (cmd_pulse_width > cmd_wave_length);
  assign is_config = (cmd_op == OP_CONFIG);
  assign cmd_mask  = NUM_CH'(1) << cmd_ch;
  assign ch_q_mask = NUM_CH'(1) << ch_q;

  // The parameter bus doubles as the record of the command being verified.
  assign rb_match = (rb_wave_length == pwm_wave_length) &&
                    (rb_pulse_width == pwm_pulse_width) &&
                    (rb_active_high == pwm_active_high);

  pwm_readback_mux #(
    .NUM_CH         (NUM_CH),
    .WAVE_LEN_WIDTH (WAVE_LEN_WIDTH)
  ) u_readback_mux (
    .ch              (sel_ch),
    .wave_length_bus (ch_wave_length_in),
    .pulse_width_bus (ch_pulse_width_in),
    .active_high_bus (ch_active_high_in),
    .wave_length     (rb_wave_length),
    .pulse_width     (rb_pulse_width),
    .active_high     (rb_active_high)
  );

  // Single sequencer FSM; every output is a register so strobes are glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      ch_q            <= '0;
      rsp_valid       <= 1'b0;
      rsp_status      <= ST_OK;
      rsp_wave_length <= '0;
      rsp_pulse_width <= '0;
      rsp_active_high <= 1'b0;
      pwm_update      <= '0;
      pwm_wave_length <= '0;
      pwm_pulse_width <= '0;
      pwm_active_high <= 1'b0;
      pwm_enable      <= '0;
    end else begin
      pwm_update <= '0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            ch_q <= cmd_ch;
            if (bad_ch || (is_config && bad_param)) begin
              rsp_status      <= bad_ch ? ST_BAD_CH : ST_BAD_PARAM;
              rsp_wave_length <= '0;
              rsp_pulse_width <= '0;
              rsp_active_high <= 1'b0;
              rsp_valid       <= 1'b1;
              state           <= S_RESP;
            end else if (is_config) begin
              pwm_wave_length <= cmd_wave_length;
              pwm_pulse_width <= cmd_pulse_width;
              pwm_active_high <= cmd_active_high;
              state           <= S_SETUP;
            end else begin
              if (cmd_op == OP_ENABLE) begin
                pwm_enable <= pwm_enable | cmd_mask;
              end else if (cmd_op == OP_DISABLE) begin
                pwm_enable <= pwm_enable & ~cmd_mask;
              end
              rsp_status      <= ST_OK;
              rsp_wave_length <= rb_wave_length;
              rsp_pulse_width <= rb_pulse_width;
              rsp_active_high <= rb_active_high;
              rsp_valid       <= 1'b1;
              state           <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          pwm_update <= ch_q_mask;
          state      <= S_STROBE;
        end
        S_STROBE: begin
          state <= S_VERIFY;
        end
        S_VERIFY: begin
          rsp_status      <= rb_match ? ST_OK : ST_MISMATCH;
          rsp_wave_length <= rb_wave_length;
          rsp_pulse_width <= rb_pulse_width;
          rsp_active_high <= rb_active_high;
          rsp_valid       <= 1'b1;
          state           <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
